// File: rtl/mult_arb_pkg.sv
// Shared types and default sizes for the multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 8;

endpackage

// File: rtl/mult_arb_pick.sv
// Combinational picker: first pending request found scanning upward from base_i, wrapping.
module mult_arb_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   base_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   id_o,
    output logic             any_o
);

    localparam int unsigned SW = IDW + 1;

    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;

    // base + k never exceeds 2*N_REQ-2, so one conditional subtract wraps it
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, base_i} + SW'(k);
            if (sum >= SW'(N_REQ)) begin
                sum = sum - SW'(N_REQ);
            end
            idx = sum[IDW-1:0];
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                id_o       = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one shift-add multiplier among N_REQ requesters with a valid/ready response port.
// Define MULT_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = N_REQ_DEF,
    parameter  int unsigned WIDTH = WIDTH_DEF,
    localparam int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_p,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [2*WIDTH-1:0]     resp_p
);

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 start_q, start_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 valid_q, valid_d;

    logic [N_REQ-1:0]     pick_gnt;
    logic [IDW-1:0]       pick_id;
    logic                 pick_any;
    logic [IDW-1:0]       base;

`ifdef MULT_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]       ptr_q, ptr_d;
    assign base = ptr_q;
`else
    assign base = '0;
`endif

    mult_arb_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i  (req),
        .base_i (base),
        .gnt_o  (pick_gnt),
        .id_o   (pick_id),
        .any_o  (pick_any)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        start_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        p_d     = p_q;
        valid_d = valid_q;
`ifdef MULT_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = ISSUE;
                    gnt_d   = pick_gnt;
                    start_d = 1'b1;
                    id_d    = pick_id;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (pick_gnt[i]) begin
                            a_d = op_a[i*WIDTH +: WIDTH];
                            b_d = op_b[i*WIDTH +: WIDTH];
                        end
                    end
`ifdef MULT_ARB_ROUND_ROBIN_EN
                    ptr_d = (pick_id == IDW'(N_REQ - 1)) ? '0 : pick_id + IDW'(1);
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    p_d     = mul_p;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
`ifdef MULT_ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            p_q     <= p_d;
            valid_q <= valid_d;
`ifdef MULT_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign mul_start  = start_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign resp_valid = valid_q;
    assign resp_id    = id_q;
    assign resp_p     = p_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a latency-programmable multiplier model.
// Follows MULT_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mult_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   op_a = '0;
    logic [N*W-1:0]   op_b = '0;
    logic [N-1:0]     gnt;
    logic             mul_start;
    logic [W-1:0]     mul_a, mul_b;
    logic             mul_done;
    logic [2*W-1:0]   mul_p;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [IDW-1:0]   resp_id;
    logic [2*W-1:0]   resp_p;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] av [N];
    logic [W-1:0] bv [N];
    int           ptr_m = 0;

    int           mul_lat = 1;
    logic         done_m = 1'b0;
    logic         spur = 1'b0;
    logic [2*W-1:0] prod_m = '0;
    int           rem = 0;
    bit           busy = 1'b0;

    always #5 clk = ~clk;

    mult_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .gnt        (gnt),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_p      (mul_p),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p)
    );

    // Multiplier model: done pulse mul_lat cycles after the start cycle; junk on mul_p otherwise
    assign mul_done = done_m | spur;
    assign mul_p    = done_m ? prod_m : 16'h5A5A;

    always @(posedge clk) begin
        if (clr) begin
            done_m <= 1'b0;
            busy   <= 1'b0;
            rem    <= 0;
        end else begin
            done_m <= 1'b0;
            if (mul_start) begin
                prod_m <= 16'(mul_a) * 16'(mul_b);
                if (mul_lat <= 1) begin
                    done_m <= 1'b1;
                end else begin
                    busy <= 1'b1;
                    rem  <= mul_lat - 1;
                end
            end else if (busy) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    done_m <= 1'b1;
                    busy   <= 1'b0;
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        av[i] = a;
        bv[i] = b;
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
    endtask

    function automatic logic [2*W-1:0] prod_of(input int i);
        return 16'(av[i]) * 16'(bv[i]);
    endfunction

    // Arbitration rule: first requester at or after the pointer, wrapping
    function automatic int model_pick(input logic [N-1:0] r);
        int base;
`ifdef MULT_ARB_ROUND_ROBIN_EN
        base = ptr_m;
`else
        base = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic model_grant(input int i);
`ifdef MULT_ARB_ROUND_ROBIN_EN
        ptr_m = (i + 1) % N;
`else
        ptr_m = 0;
`endif
    endtask

    // Drives one request and collects what the DUT did; bounded waits, no checking here
    task automatic run_txn(input logic [N-1:0] rq, input bit keep, input int lat,
                           output logic [N-1:0] g, output logic st,
                           output logic [W-1:0] a, output logic [W-1:0] b,
                           output int gw, output logic [IDW-1:0] id,
                           output logic [2*W-1:0] p, output int rw,
                           output bit extra, output bit ok);
        g = '0; st = 1'b0; a = '0; b = '0; gw = 0; id = '0; p = '0; rw = 0;
        extra = 1'b0; ok = 1'b0;
        mul_lat    = lat;
        resp_ready = 1'b1;
        req        = rq;
        for (int i = 1; i <= 20 && gw == 0; i++) begin
            @(negedge clk);
            if (gnt != 0) begin
                gw = i; g = gnt; st = mul_start; a = mul_a; b = mul_b;
            end
        end
        if (gw == 0) return;
        if (!keep) req = req & ~g;
        for (int i = 1; i <= 40 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1; rw = i; id = resp_id; p = resp_p;
            end else if (gnt != 0 || mul_start) begin
                extra = 1'b1;
            end
        end
    endtask

    logic [N-1:0]   t_g;
    logic           t_st;
    logic [W-1:0]   t_a, t_b;
    int             t_gw, t_rw;
    logic [IDW-1:0] t_id;
    logic [2*W-1:0] t_p;
    bit             t_extra, t_ok;

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, mul_start, mul_a, mul_b, resp_valid, resp_id, resp_p} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b start=%b a=%h b=%h v=%b id=%0d p=%h, want all 0",
                     gnt, mul_start, mul_a, mul_b, resp_valid, resp_id, resp_p);
        end
        clr = 1'b0;
        ptr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_op(0, 8'd3, 8'd5);
        set_op(1, 8'd7, 8'd9);
        set_op(2, 8'd11, 8'd13);
        set_op(3, 8'd17, 8'd19);
        run_txn(4'b0001, 1'b0, 6, t_g, t_st, t_a, t_b, t_gw, t_id, t_p, t_rw, t_extra, t_ok);
        model_grant(0);
        checks++;
        if (!t_ok) begin errors++; $display("FAIL single_done: no response within bound"); end
        checks++;
        if (t_gw !== 1) begin errors++; $display("FAIL single_gnt_latency: got %0d want 1", t_gw); end
        checks++;
        if ({t_g, t_st} !== {4'b0001, 1'b1}) begin
            errors++; $display("FAIL single_gnt: got gnt=%b start=%b want 0001/1", t_g, t_st);
        end
        checks++;
        if ({t_a, t_b} !== {8'd3, 8'd5}) begin
            errors++; $display("FAIL single_operands: got a=%0d b=%0d want 3/5", t_a, t_b);
        end
        checks++;
        if (t_extra !== 1'b0) begin errors++; $display("FAIL single_pulse_width: gnt/start seen after issue cycle"); end
        checks++;
        if ({t_id, t_p} !== {2'd0, 16'd15}) begin
            errors++; $display("FAIL single_resp: got id=%0d p=%0d want 0/15", t_id, t_p);
        end
        checks++;
        if (t_rw !== 7) begin errors++; $display("FAIL single_resp_latency: got %0d want 7", t_rw); end
        req = '0;
    endtask

    task automatic test_contention();
        int exp;
        for (int n = 0; n < 5; n++) begin
            exp = model_pick(4'b1111);
            run_txn(4'b1111, 1'b1, 2, t_g, t_st, t_a, t_b, t_gw, t_id, t_p, t_rw, t_extra, t_ok);
            model_grant(exp);
            checks++;
            if (!t_ok || t_g !== (4'b0001 << exp) || t_id !== IDW'(exp) || t_p !== prod_of(exp)) begin
                errors++;
                $display("FAIL contention_%0d: got ok=%b gnt=%b id=%0d p=%0d want gnt=%b id=%0d p=%0d",
                         n, t_ok, t_g, t_id, t_p, 4'b0001 << exp, exp, prod_of(exp));
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int exp;
        bit seen;
        logic [2*W-1:0] ep;
        set_op(0, 8'd200, 8'd3);
        resp_ready = 1'b0;
        mul_lat = 3;
        req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 0) seen = 1'b1;
        end
        req = '0;
        model_grant(0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_valid: no response within bound"); end
        ep = prod_of(0);
        req = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_valid, resp_id, resp_p, gnt} !== {1'b1, 2'd0, ep, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b id=%0d p=%h gnt=%b want 1/0/%h/0000",
                         i, resp_valid, resp_id, resp_p, gnt, ep);
            end
        end
        exp = model_pick(4'b0110);
        run_txn(4'b0110, 1'b0, 4, t_g, t_st, t_a, t_b, t_gw, t_id, t_p, t_rw, t_extra, t_ok);
        model_grant(exp);
        checks++;
        if (t_gw !== 2) begin errors++; $display("FAIL bp_next_grant_delay: got %0d want 2", t_gw); end
        checks++;
        if (!t_ok || t_id !== IDW'(exp) || t_p !== prod_of(exp)) begin
            errors++;
            $display("FAIL bp_next_resp: got ok=%b id=%0d p=%0d want id=%0d p=%0d",
                     t_ok, t_id, t_p, exp, prod_of(exp));
        end
        req = '0;
    endtask

    task automatic test_clr_wait();
        int cnt;
        int exp;
        bit seen;
        resp_ready = 1'b1;
        mul_lat = 20;
        req = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 0) seen = 1'b1;
        end
        req = '0;
        model_grant(1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, mul_start, mul_a, mul_b, resp_valid, resp_id, resp_p} !== '0) begin
            errors++;
            $display("FAIL clr_outputs: got gnt=%b start=%b a=%h b=%h v=%b id=%0d p=%h, want all 0",
                     gnt, mul_start, mul_a, mul_b, resp_valid, resp_id, resp_p);
        end
        clr = 1'b0;
        ptr_m = 0;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL clr_no_resp: got %0d valid cycles want 0", cnt); end
        exp = model_pick(4'b0110);
        run_txn(4'b0110, 1'b0, 2, t_g, t_st, t_a, t_b, t_gw, t_id, t_p, t_rw, t_extra, t_ok);
        model_grant(exp);
        checks++;
        if (!t_ok || t_id !== IDW'(exp)) begin
            errors++; $display("FAIL clr_ptr_restart: got ok=%b id=%0d want %0d", t_ok, t_id, exp);
        end
        req = '0;
        run_txn(4'b0100, 1'b0, 2, t_g, t_st, t_a, t_b, t_gw, t_id, t_p, t_rw, t_extra, t_ok);
        model_grant(2);
        checks++;
        if (!t_ok || t_id !== 2'd2 || t_p !== prod_of(2)) begin
            errors++; $display("FAIL clr_then_req2: got ok=%b id=%0d p=%0d want 2/%0d", t_ok, t_id, t_p, prod_of(2));
        end
        req = '0;
    endtask

    task automatic test_spurious();
        int cnt;
        bit seen;
        logic [2*W-1:0] ep;
        req = '0;
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid || gnt != 0) cnt++;
        end
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL spur_idle: got %0d active cycles want 0", cnt); end
        set_op(3, 8'd21, 8'd10);
        resp_ready = 1'b0;
        mul_lat = 2;
        req = 4'b1000;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 0) seen = 1'b1;
        end
        req = '0;
        model_grant(3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        ep = prod_of(3);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        checks++;
        if ({resp_valid, resp_id, resp_p} !== {1'b1, 2'd3, ep}) begin
            errors++; $display("FAIL spur_resp: got v=%b id=%0d p=%h want 1/3/%h", resp_valid, resp_id, resp_p, ep);
        end
        resp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL spur_extra_resp: got %0d valid cycles want 0", cnt); end
    endtask

    task automatic test_boundary();
        set_op(3, 8'd255, 8'd255);
        run_txn(4'b1000, 1'b0, 4, t_g, t_st, t_a, t_b, t_gw, t_id, t_p, t_rw, t_extra, t_ok);
        model_grant(3);
        checks++;
        if (!t_ok || t_id !== 2'd3 || t_p !== 16'hFE01) begin
            errors++; $display("FAIL max_operands: got ok=%b id=%0d p=%h want 3/fe01", t_ok, t_id, t_p);
        end
        set_op(1, 8'd0, 8'd200);
        run_txn(4'b0010, 1'b0, 1, t_g, t_st, t_a, t_b, t_gw, t_id, t_p, t_rw, t_extra, t_ok);
        model_grant(1);
        checks++;
        if (!t_ok || t_p !== 16'h0000 || t_rw !== 2) begin
            errors++; $display("FAIL zero_fast_done: got ok=%b p=%h rw=%0d want p=0000 rw=2", t_ok, t_p, t_rw);
        end
        req = '0;
    endtask

    task automatic test_random();
        int exp;
        int lat;
        logic [N-1:0] rq;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
            rq = N'($urandom_range(1, 15));
            lat = $urandom_range(1, 8);
            exp = model_pick(rq);
            run_txn(rq, 1'b0, lat, t_g, t_st, t_a, t_b, t_gw, t_id, t_p, t_rw, t_extra, t_ok);
            model_grant(exp);
            req = '0;
            checks++;
            if (!t_ok || t_g !== (4'b0001 << exp) || t_id !== IDW'(exp)) begin
                errors++;
                $display("FAIL rand_grant_%0d: req=%b got ok=%b gnt=%b id=%0d want id=%0d",
                         n, rq, t_ok, t_g, t_id, exp);
            end
            checks++;
            if ({t_a, t_b} !== {av[exp], bv[exp]}) begin
                errors++;
                $display("FAIL rand_operands_%0d: got a=%0d b=%0d want %0d/%0d", n, t_a, t_b, av[exp], bv[exp]);
            end
            checks++;
            if (t_p !== prod_of(exp) || t_rw !== lat + 1) begin
                errors++;
                $display("FAIL rand_product_%0d: got p=%0d rw=%0d want p=%0d rw=%0d",
                         n, t_p, t_rw, prod_of(exp), lat + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_clr_wait();
        test_spurious();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
